// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned memory requests under a
// credit limit, buffers in-order responses and squashes stale ones after a redirect.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // inflight/drop can exceed FIFO_DEPTH after redirects; 8 bits covers any sane memory latency
    localparam int unsigned CW  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fresh, occupancy;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
    logic [31:0]   data_q  [FIFO_DEPTH];
    logic [31:0]   addr_q  [FIFO_DEPTH];
    logic [31:0]   aq_q    [FIFO_DEPTH];
    logic          accept, push, pop;
    logic          rpc_unused;

    assign rpc_unused = ^redirect_pc[1:0];

    always_comb begin
        fresh          = inflight_q - drop_q;
        occupancy      = fresh + CW'(count_q);
        imem_addr      = pc_q;
        imem_req_valid = rst_n && !redirect_valid && (occupancy < CW'(FIFO_DEPTH));
        accept         = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && !redirect_valid && (drop_q == '0);
        pop            = (count_q != '0) && instr_ready && !redirect_valid;

        instr_valid    = (count_q != '0);
        Instruction    = instr_valid ? data_q[rd_q] : NOP;
        instr_pc       = instr_valid ? addr_q[rd_q] : '0;
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_d     = drop_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        aq_rd_d    = push ? aq_rd_q + 1'b1 : aq_rd_q;
        aq_wr_d    = accept ? aq_wr_q + 1'b1 : aq_wr_q;

        if (accept) begin
            pc_d = pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        // Everything still in flight is stale; a response landing now is discarded as well.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            drop_d  = inflight_q - CW'(imem_rsp_valid);
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            aq_rd_d = '0;
            aq_wr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            aq_q[aq_wr_q] <= pc_q;
        end
        if (push) begin
            data_q[wr_q] <= imem_rsp_data;
            addr_q[wr_q] <= aq_q[aq_rd_q];
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: table-driven cycle vectors against an in-order
// latency-configurable memory model, plus hand sequences for redirect/reset corners.
module tb_rv32i_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] Instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    rv32i_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .Instruction   (Instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        string       nm;
        bit          rst;
        int          lat;
        bit          rdy;
        bit          ir;
        bit          redir;
        logic [31:0] rpc;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    mreq_t mq[$];
    vec_t  vt[$];
    int    cyc;
    int    lat;
    int    checks;
    int    failures;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    function automatic void add(input string nm, input bit rst, input int l, input bit rdy,
                                input bit ir, input bit redir, input logic [31:0] rpc,
                                input bit rv, input logic [31:0] addr, input bit iv,
                                input logic [31:0] ipc);
        vec_t v;
        v.nm = nm; v.rst = rst; v.lat = l; v.rdy = rdy; v.ir = ir; v.redir = redir;
        v.rpc = rpc; v.rv = rv; v.addr = addr; v.iv = iv; v.ipc = ipc;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sample_accept();
        mreq_t m;
        if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
        end
    endtask

    // Advance one clock; the memory retires the response it just presented and
    // presents the next one whose latency has elapsed.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memw(mq[0].addr);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample_accept();
        tick();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq.delete();
        repeat (2) @(negedge clk);
        chk("reset.req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset.instr_valid", 32'(instr_valid), 32'd0);
        chk("reset.Instruction", Instruction, 32'h0000_0013);
        chk("reset.instr_pc", instr_pc, 32'h0);
        chk("reset.imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; lat = 1;
        rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Streaming at latency 1: the credit check sees the head before it pops, so a
        // request slot is skipped every third cycle; then memory backpressure.
        add("s.c0", 1, 1, 1, 1, 0, 0, 1, 32'h00, 0, 0);
        add("s.c1", 0, 1, 1, 1, 0, 0, 1, 32'h04, 0, 0);
        add("s.c2", 0, 1, 1, 1, 0, 0, 0, 32'h08, 1, 32'h00);
        add("s.c3", 0, 1, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04);
        add("s.c4", 0, 1, 1, 1, 0, 0, 1, 32'h0C, 0, 0);
        add("s.c5", 0, 1, 1, 1, 0, 0, 0, 32'h10, 1, 32'h08);
        add("s.c6", 0, 1, 1, 1, 0, 0, 1, 32'h10, 1, 32'h0C);
        add("s.c7", 0, 1, 0, 1, 0, 0, 1, 32'h14, 0, 0);
        add("s.c8", 0, 1, 0, 1, 0, 0, 1, 32'h14, 1, 32'h10);
        add("s.c9", 0, 1, 1, 1, 0, 0, 1, 32'h14, 0, 0);
        add("s.c10", 0, 1, 1, 1, 0, 0, 1, 32'h18, 0, 0);
        // Decode stall for 10 cycles: exactly two requests, then pc holds at 0x8.
        add("st.c0", 1, 1, 1, 0, 0, 0, 1, 32'h00, 0, 0);
        add("st.c1", 0, 1, 1, 0, 0, 0, 1, 32'h04, 0, 0);
        for (int i = 2; i < 10; i++)
            add($sformatf("st.c%0d", i), 0, 1, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00);
        add("st.c10", 0, 1, 1, 1, 0, 0, 0, 32'h08, 1, 32'h00);
        add("st.c11", 0, 1, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04);
        add("st.c12", 0, 1, 1, 1, 0, 0, 1, 32'h0C, 0, 0);
        add("st.c13", 0, 1, 1, 1, 0, 0, 0, 32'h10, 1, 32'h08);
        // Latency 3, redirect with two requests outstanding: both responses dropped.
        add("rd.c0", 1, 3, 1, 1, 0, 0, 1, 32'h00, 0, 0);
        add("rd.c1", 0, 3, 1, 1, 0, 0, 1, 32'h04, 0, 0);
        add("rd.c2", 0, 3, 1, 1, 1, 32'h100, 0, 32'h08, 0, 0);
        add("rd.c3", 0, 3, 1, 1, 0, 0, 1, 32'h100, 0, 0);
        add("rd.c4", 0, 3, 1, 1, 0, 0, 1, 32'h104, 0, 0);
        add("rd.c5", 0, 3, 1, 1, 0, 0, 0, 32'h108, 0, 0);
        add("rd.c6", 0, 3, 1, 1, 0, 0, 0, 32'h108, 0, 0);
        add("rd.c7", 0, 3, 1, 1, 0, 0, 0, 32'h108, 1, 32'h100);
        add("rd.c8", 0, 3, 1, 1, 0, 0, 1, 32'h108, 1, 32'h104);
        // Unaligned redirect target, redirect over an arriving response, pc wrap.
        add("al.c0", 1, 1, 1, 1, 1, 32'h203, 0, 32'h00, 0, 0);
        add("al.c1", 0, 1, 1, 1, 0, 0, 1, 32'h200, 0, 0);
        add("al.c2", 0, 1, 1, 1, 1, 32'hFFFF_FFFF, 0, 32'h204, 0, 0);
        add("al.c3", 0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        add("al.c4", 0, 1, 1, 1, 0, 0, 1, 32'h0000_0000, 0, 0);
        add("al.c5", 0, 1, 1, 1, 0, 0, 0, 32'h0000_0004, 1, 32'hFFFF_FFFC);

        for (int i = 0; i < vt.size(); i++) begin
            vec_t v;
            v = vt[i];
            if (v.rst) do_reset();
            lat            = v.lat;
            imem_req_ready = v.rdy;
            instr_ready    = v.ir;
            redirect_valid = v.redir;
            redirect_pc    = v.rpc;
            @(negedge clk);
            chk({v.nm, ".req_valid"}, 32'(imem_req_valid), 32'(v.rv));
            chk({v.nm, ".imem_addr"}, imem_addr, v.addr);
            chk({v.nm, ".instr_valid"}, 32'(instr_valid), 32'(v.iv));
            chk({v.nm, ".instr_pc"}, instr_pc, v.iv ? v.ipc : 32'h0);
            chk({v.nm, ".Instruction"}, Instruction, v.iv ? memw(v.ipc) : 32'h0000_0013);
            sample_accept();
            tick();
        end
        redirect_valid = 1'b0;

        // Redirect coinciding with a response and a pop while one entry is buffered.
        do_reset();
        lat = 2; imem_req_ready = 1'b1; instr_ready = 1'b1;
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        chk("rr.t.instr_valid", 32'(instr_valid), 32'd1);
        chk("rr.t.instr_pc", instr_pc, 32'h0);
        chk("rr.t.rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("rr.t.req_valid", 32'(imem_req_valid), 32'd0);
        sample_accept();
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rr.t1.instr_valid", 32'(instr_valid), 32'd0);
        chk("rr.t1.Instruction", Instruction, 32'h0000_0013);
        chk("rr.t1.req_valid", 32'(imem_req_valid), 32'd1);
        chk("rr.t1.imem_addr", imem_addr, 32'h40);
        sample_accept();
        tick();
        @(negedge clk);
        chk("rr.t2.req_valid", 32'(imem_req_valid), 32'd1);
        chk("rr.t2.imem_addr", imem_addr, 32'h44);
        sample_accept();
        tick();
        step();
        @(negedge clk);
        chk("rr.t4.instr_valid", 32'(instr_valid), 32'd1);
        chk("rr.t4.instr_pc", instr_pc, 32'h40);
        chk("rr.t4.Instruction", Instruction, memw(32'h40));
        sample_accept();
        tick();

        // Asynchronous reset with the buffer full, then restart at RESET_PC.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("ar.full.instr_valid", 32'(instr_valid), 32'd1);
        chk("ar.full.req_valid", 32'(imem_req_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.async.instr_valid", 32'(instr_valid), 32'd0);
        chk("ar.async.req_valid", 32'(imem_req_valid), 32'd0);
        chk("ar.async.Instruction", Instruction, 32'h0000_0013);
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        @(negedge clk);
        chk("ar.rel.req_valid", 32'(imem_req_valid), 32'd1);
        chk("ar.rel.imem_addr", imem_addr, 32'h0);
        chk("ar.rel.instr_valid", 32'(instr_valid), 32'd0);
        sample_accept();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
